// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, counter width, latency.
// Used by div_seq (build option DIV_SIGNED_EN) and by the hazard unit / bench.
package div_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_CNT_W   = $clog2(DIV_WIDTH);
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
// Compiled only when DIV_SIGNED_EN is defined.
`ifdef DIV_SIGNED_EN
module div_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = neg_i ? -in_i : in_i;
    end

endmodule
`endif

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider (DIVU; DIV too when DIV_SIGNED_EN is defined).
// Quotient -> LO, remainder -> HI; fixed WIDTH+2 busy cycles, valid in the last one.
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
`ifdef DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbzo_q, dbzo_d;

    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic             accept;

`ifdef DIV_SIGNED_EN
    logic sign_a, sign_b;
    logic qneg_q, qneg_d, rneg_q, rneg_d;

    assign sign_a = is_signed & dividend[WIDTH-1];
    assign sign_b = is_signed & divisor[WIDTH-1];

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.in_i(dividend),       .neg_i(sign_a), .out_o(a_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.in_i(divisor),        .neg_i(sign_b), .out_o(b_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.in_i(q_q),            .neg_i(qneg_q), .out_o(q_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.in_i(r_q[WIDTH-1:0]), .neg_i(rneg_q), .out_o(r_fix));

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            qneg_d = sign_a ^ sign_b;
            rneg_d = sign_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = q_q;
    assign r_fix = r_q[WIDTH-1:0];
`endif

    assign accept = (state_q == DIV_IDLE) && start && !cancel;

    // Trial subtract carries two spare MSBs so the sign bit is exact for any shifted remainder.
    assign trial = {r_q, q_q[WIDTH-1]} - {2'b00, d_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        a_d     = a_q;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbzo_d  = dbzo_q;

        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    a_d     = dividend;
                    q_d     = a_mag;
                    d_d     = b_mag;
                    r_d     = '0;
                    dbz_d   = (divisor == '0);
                    cnt_d   = '0;
                    state_d = DIV_CALC;
                end
            end
            DIV_CALC: begin
                r_d   = trial[WIDTH+1] ? {r_q[WIDTH-1:0], q_q[WIDTH-1]} : trial[WIDTH:0];
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                quot_d  = dbz_q ? '1  : q_fix;
                rem_d   = dbz_q ? a_q : r_fix;
                dbzo_d  = dbz_q;
                state_d = DIV_DONE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // A flush abandons the operation and leaves the previous results visible.
        if (cancel && (state_q != DIV_IDLE)) begin
            state_d = DIV_IDLE;
            quot_d  = quot_q;
            rem_d   = rem_q;
            dbzo_d  = dbzo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            a_q     <= '0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbzo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            a_q     <= a_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbzo_q  <= dbzo_d;
        end
    end

    assign busy        = (state_q != DIV_IDLE);
    assign valid       = (state_q == DIV_DONE) && !cancel;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; signed vectors run when DIV_SIGNED_EN is defined.
module tb_div_seq;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [31:0] dividend, divisor;
    logic        busy, valid, div_by_zero;
    logic [31:0] quotient, remainder;
`ifdef DIV_SIGNED_EN
    logic        is_signed;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cancel      (cancel),
`ifdef DIV_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; issues one request and checks latency, results and the valid pulse.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input bit repulse);
        int unsigned cyc  = 0;
        bit          done = 1'b0;
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        is_signed = sgn;
`else
        if (sgn) $display("note: %s needs DIV_SIGNED_EN", tag);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (busy) cyc++;
            if (valid) begin
                done = 1'b1;
                check({tag, ".q"},   quotient,    eq);
                check({tag, ".r"},   remainder,   er);
                check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
            end else begin
                if (repulse && cyc == 5) begin
                    dividend = 32'd9;
                    divisor  = 32'd3;
                    start    = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".lat"},  cyc, DIV_LATENCY);
        // start during the valid cycle must be ignored
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".pulse"}, {30'd0, valid, busy}, 32'd0);
        check({tag, ".hold"},  quotient, eq);
        @(negedge clk);
        check({tag, ".idle"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int unsigned vseen;
        rst      = 1'b1;
        start    = 1'b0;
        cancel   = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_SIGNED_EN
        is_signed = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst.flags", {29'd0, busy, valid, div_by_zero}, 32'd0);
        check("rst.q", quotient, 32'd0);
        check("rst.r", remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("divu_100_7",  32'd100,        32'd7, 1'b0, 32'd14,         32'd2,         1'b0, 1'b0);
        run_div("divu_max_1",  32'hFFFF_FFFF,  32'd1, 1'b0, 32'hFFFF_FFFF,  32'd0,         1'b0, 1'b0);
        run_div("divu_5_9",    32'd5,          32'd9, 1'b0, 32'd0,          32'd5,         1'b0, 1'b0);
        run_div("dbz",         32'h1234_5678,  32'd0, 1'b0, 32'hFFFF_FFFF,  32'h1234_5678, 1'b1, 1'b0);
        run_div("divu_min_3",  32'h8000_0000,  32'd3, 1'b0, 32'h2AAA_AAAA,  32'd2,         1'b0, 1'b0);
`ifdef DIV_SIGNED_EN
        run_div("div_m7_2",    32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div("div_7_m2",    32'd7,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
        run_div("div_m7_m2",   32'hFFFF_FFF9,  32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div("div_min_m1",  32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 1'b0);
        run_div("div_m7_0",    32'hFFFF_FFF9,  32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
        run_div("divu_m7_2",   32'hFFFF_FFF9,  32'd2,         1'b0, 32'h7FFF_FFFC, 32'd1,         1'b0, 1'b0);
`endif
        run_div("divu_1000_10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0);

        // cancel on CALC cycle 10
        vseen    = 0;
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (valid) vseen++;
            @(negedge clk);
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel.novalid", vseen + {31'd0, valid}, 32'd0);
        check("cancel.busy", {31'd0, busy}, 32'd0);
        check("cancel.q", quotient, 32'd100);
        check("cancel.r", remainder, 32'd0);
        run_div("after_cancel", 32'd50, 32'd3, 1'b0, 32'd16, 32'd2, 1'b0, 1'b0);

        // cancel together with start in IDLE rejects the request
        dividend = 32'd77;
        divisor  = 32'd7;
        start    = 1'b1;
        cancel   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_start.busy", {31'd0, busy}, 32'd0);

        run_div("repulse", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);

        // reset mid-CALC
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.flags", {29'd0, busy, valid, div_by_zero}, 32'd0);
        check("midrst.q", quotient, 32'd0);
        check("midrst.r", remainder, 32'd0);
        vseen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid || busy) vseen++;
            @(negedge clk);
        end
        check("midrst.novalid", vseen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
